// File: rtl/fft2d_io_ctrl.sv
// fft2d_io_ctrl
//   Sequences the FFT2D I/O FIFO. It generates the FIFO chip selects and
//   enables, and it selects one of three bus modes:
//     LOAD  - the external port fills the FIFO with one frame.
//     DRAIN - one frame of FIFO words goes round-robin to the FFT units.
//     PASS  - both chip selects are low, so the I/O block shorts the
//             external port to the units bus.
//   A one-cycle FIN state ends each LOAD or DRAIN frame and pulses done.
//
// Ports
//   clk, reset               rising-edge clock; asynchronous active-low reset
//   start_load, start_drain  frame requests, sampled only in IDLE
//   pass_req                 level request for PASS mode
//   abort                    ends LOAD/DRAIN/PASS at once, with no done pulse
//   ext_valid, ext_ready     handshake for words on the external port
//   fifo_empty, fifo_full    FIFO status flags
//   unit_ready               per-unit ready flags
//   wr_cs, rd_cs             FIFO chip selects
//   wr_en, rd_en             FIFO enables
//   unit_sel, unit_load      target unit index and one-hot capture strobe
//   word_cnt                 number of words moved in the current frame
//   busy, done               not-IDLE flag; frame-complete pulse
module fft2d_io_ctrl #(
    parameter int FRAME_WORDS = 32,
    parameter int NUM_UNITS   = 32,
    parameter int CNT_W       = 6,
    parameter int SEL_W       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_load,
    input  logic                 start_drain,
    input  logic                 pass_req,
    input  logic                 abort,
    input  logic                 ext_valid,
    output logic                 ext_ready,
    input  logic                 fifo_empty,
    input  logic                 fifo_full,
    input  logic [NUM_UNITS-1:0] unit_ready,
    output logic                 wr_cs,
    output logic                 rd_cs,
    output logic                 wr_en,
    output logic                 rd_en,
    output logic [SEL_W-1:0]     unit_sel,
    output logic [NUM_UNITS-1:0] unit_load,
    output logic [CNT_W-1:0]     word_cnt,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        PASS  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t state, next;

    logic [NUM_UNITS-1:0] sel_mask;
    logic                 sel_ready;
    logic                 last_word;
    logic                 sel_last;

    // The one-hot mask gives the ready lookup and the capture strobe without
    // indexing a NUM_UNITS-wide vector with a SEL_W-wide index.
    assign sel_mask  = NUM_UNITS'(1) << unit_sel;
    assign sel_ready = |(unit_ready & sel_mask);
    assign last_word = (word_cnt == CNT_W'(FRAME_WORDS - 1));
    assign sel_last  = (unit_sel == SEL_W'(NUM_UNITS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next      = state;
        wr_cs     = 1'b0;
        rd_cs     = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        ext_ready = 1'b0;
        unit_load = '0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_load)       next = LOAD;
                else if (start_drain) next = DRAIN;
                else if (pass_req)    next = PASS;
            end
            LOAD: begin
                wr_cs     = 1'b1;
                // abort removes every enable in the same cycle.
                ext_ready = !fifo_full && !abort;
                wr_en     = ext_valid && !fifo_full && !abort;
                if (abort)                  next = IDLE;
                else if (wr_en && last_word) next = FIN;
            end
            DRAIN: begin
                rd_cs     = 1'b1;
                rd_en     = !fifo_empty && sel_ready && !abort;
                unit_load = rd_en ? sel_mask : '0;
                if (abort)                  next = IDLE;
                else if (rd_en && last_word) next = FIN;
            end
            PASS: begin
                if (abort || !pass_req) next = IDLE;
            end
            FIN: begin
                done = 1'b1;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // The counters use the same asynchronous reset, so word_cnt and unit_sel
    // read 0 as soon as reset is asserted. word_cnt keeps its final value
    // through FIN and IDLE until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt <= '0;
            unit_sel <= '0;
        end else if (state == IDLE && next != IDLE) begin
            word_cnt <= '0;
            unit_sel <= '0;
        end else if (wr_en || rd_en) begin
            word_cnt <= word_cnt + 1'b1;
            if (rd_en) unit_sel <= sel_last ? '0 : unit_sel + 1'b1;
        end
    end

endmodule
